// File: rtl/vga_timing_decoder_if.sv
// Sync inputs and recovered-timing outputs of the VGA timing decoder.
// The master side is the sync source/consumer, the slave side is the decoder.
interface vga_timing_decoder_if;
   logic       hsync_n;
   logic       vsync_n;
   logic [9:0] pixel_x;
   logic [9:0] line_y;
   logic       pixel_tick;
   logic       video_active;
   logic       locked;
   logic       frame_start;
   logic       h_error;
   logic       v_error;

   modport master (
      output hsync_n, vsync_n,
      input  pixel_x, line_y, pixel_tick, video_active, locked, frame_start, h_error, v_error
   );

   modport slave (
      input  hsync_n, vsync_n,
      output pixel_x, line_y, pixel_tick, video_active, locked, frame_start, h_error, v_error
   );
endinterface

// File: rtl/vga_timing_decoder.sv
// Recovers pixel/line position from incoming VGA sync pulses and tracks lock:
// SEARCH -> H_LOCK on any hsync edge, H_LOCK -> LOCKED on vsync after a full-length line.
module vga_timing_decoder #(
   parameter int SUB_PIXEL_WIDTH = 2,
   parameter int PIXELS          = 800,
   parameter int LINES           = 525,
   parameter int H_VISIBLE       = 640,
   parameter int V_VISIBLE       = 480,
   parameter int H_SYNC_START    = 656,
   parameter int V_SYNC_START    = 490
) (
   input logic                 clk,
   input logic                 reset,
   input logic                 enable,
   vga_timing_decoder_if.slave vid
);

   localparam int CNT_W = $clog2(PIXELS + H_SYNC_START + 1);

   localparam logic [SUB_PIXEL_WIDTH-1:0] SUB_LAST = '1;
   localparam logic [SUB_PIXEL_WIDTH-1:0] SUB_ONE  = SUB_PIXEL_WIDTH'(1);
   localparam logic [9:0] X_LAST = 10'(PIXELS - 1);
   localparam logic [9:0] Y_LAST = 10'(LINES - 1);
   localparam logic [9:0] X_SYNC = 10'(H_SYNC_START);
   localparam logic [9:0] Y_SYNC = 10'(V_SYNC_START);
   localparam logic [9:0] X_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] Y_VIS  = 10'(V_VISIBLE);
   localparam logic [CNT_W-1:0] WD_SAT  = CNT_W'(PIXELS + H_SYNC_START);
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(PIXELS + H_SYNC_START - 1);
   localparam logic [CNT_W-1:0] SPACING = CNT_W'(PIXELS);

   typedef enum logic [1:0] {SEARCH, H_LOCK, LOCKED} state_t;

   state_t                     state_q, state_d;
   logic                       hs_q, hs_d, vs_q, vs_d;
   logic [SUB_PIXEL_WIDTH-1:0] sub_q, sub_d;
   logic [9:0]                 x_q, x_d, y_q, y_d;
   logic [CNT_W-1:0]           hcnt_q, hcnt_d;
   logic                       hspace_ok_q, hspace_ok_d;
   logic                       pixel_tick_q, pixel_tick_d;
   logic                       video_active_q, video_active_d;
   logic                       locked_q, locked_d;
   logic                       frame_start_q, frame_start_d;
   logic                       h_error_q, h_error_d;
   logic                       v_error_q, v_error_d;

   logic h_edge, v_edge, tick, wd_fire, h_fault, v_fault;

   assign h_edge  = hs_q & ~vid.hsync_n;
   assign v_edge  = vs_q & ~vid.vsync_n;
   assign tick    = (sub_q == SUB_LAST);
   assign wd_fire = tick && !h_edge && (hcnt_q == WD_LAST);
   assign h_fault = (state_q != SEARCH) && ((h_edge && (x_q != X_SYNC)) || wd_fire);
   assign v_fault = (state_q == LOCKED) && v_edge && (y_q != Y_SYNC);

   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         state_q <= SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SEARCH:  if (h_edge) state_d = H_LOCK;
         H_LOCK: begin
            if (h_fault)                    state_d = SEARCH;
            else if (v_edge && hspace_ok_q) state_d = LOCKED;
         end
         LOCKED: begin
            if (h_fault)      state_d = SEARCH;
            else if (v_fault) state_d = H_LOCK;
         end
         default: state_d = SEARCH;
      endcase
   end

   // Sync edges re-anchor the free-running position; they win over the normal advance.
   always_comb begin
      hs_d  = vid.hsync_n;
      vs_d  = vid.vsync_n;
      sub_d = sub_q + SUB_ONE;
      x_d   = x_q;
      y_d   = y_q;
      if (tick) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
      if (h_edge) begin
         sub_d = SUB_ONE;
         x_d   = X_SYNC;
         y_d   = y_q;
      end
      if (v_edge) begin
         y_d = Y_SYNC;
      end

      hcnt_d = hcnt_q;
      if (h_edge) begin
         hcnt_d = '0;
      end else if (tick && (hcnt_q != WD_SAT)) begin
         hcnt_d = hcnt_q + CNT_W'(1);
      end

      // Only a spacing measured between two edges seen outside SEARCH qualifies for lock.
      hspace_ok_d = hspace_ok_q;
      if (state_d == SEARCH) begin
         hspace_ok_d = 1'b0;
      end else if (h_edge) begin
         hspace_ok_d = (state_q != SEARCH) && (hcnt_q == SPACING);
      end

      pixel_tick_d = (sub_d == SUB_LAST);
   end

   always_comb begin
      locked_d       = (state_d == LOCKED);
      video_active_d = locked_d && (x_d < X_VIS) && (y_d < Y_VIS);
      frame_start_d  = locked_d && (x_d == 10'd0) && (y_d == 10'd0) &&
                       ((x_q != 10'd0) || (y_q != 10'd0));
      h_error_d      = h_fault;
      v_error_d      = v_fault;
   end

   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         hs_q           <= 1'b1;
         vs_q           <= 1'b1;
         sub_q          <= '0;
         x_q            <= '0;
         y_q            <= '0;
         hcnt_q         <= '0;
         hspace_ok_q    <= 1'b0;
         pixel_tick_q   <= 1'b0;
         video_active_q <= 1'b0;
         locked_q       <= 1'b0;
         frame_start_q  <= 1'b0;
         h_error_q      <= 1'b0;
         v_error_q      <= 1'b0;
      end else begin
         hs_q           <= hs_d;
         vs_q           <= vs_d;
         sub_q          <= sub_d;
         x_q            <= x_d;
         y_q            <= y_d;
         hcnt_q         <= hcnt_d;
         hspace_ok_q    <= hspace_ok_d;
         pixel_tick_q   <= pixel_tick_d;
         video_active_q <= video_active_d;
         locked_q       <= locked_d;
         frame_start_q  <= frame_start_d;
         h_error_q      <= h_error_d;
         v_error_q      <= v_error_d;
      end
   end

   assign vid.pixel_x      = x_q;
   assign vid.line_y       = y_q;
   assign vid.pixel_tick   = pixel_tick_q;
   assign vid.video_active = video_active_q;
   assign vid.locked       = locked_q;
   assign vid.frame_start  = frame_start_q;
   assign vid.h_error      = h_error_q;
   assign vid.v_error      = v_error_q;

endmodule

// File: doc/vga_timing_decoder.md
VGA_TIMING_DECODER -- requirements
Module: vga_timing_decoder

Interface
REQ-001 Parameter SUB_PIXEL_WIDTH, default 2; clocks per pixel = 2^SUB_PIXEL_WIDTH (4 at 100 MHz gives 25 MHz pixels).
REQ-002 Parameter PIXELS, default 800; total pixels per line.
REQ-003 Parameter LINES, default 525; total lines per frame.
REQ-004 Parameter H_VISIBLE, default 640; V_VISIBLE, default 480; visible width and height.
REQ-005 Parameter H_SYNC_START, default 656; V_SYNC_START, default 490; first pixel of hsync low and first line of vsync low.
REQ-006 clk  in  1  single system clock; all logic on posedge clk.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 enable  in  1  high = decode; low behaves exactly like reset asserted.
REQ-009 hsync_n  in  1  active-low horizontal sync, synchronous to clk.
REQ-010 vsync_n  in  1  active-low vertical sync, synchronous to clk.
REQ-011 pixel_x  out  10  recovered pixel position, 0..PIXELS-1.
REQ-012 line_y  out  10  recovered line position, 0..LINES-1.
REQ-013 pixel_tick  out  1  one-clk pulse on the last sub-pixel clock of each pixel.
REQ-014 video_active  out  1  high when locked, pixel_x < H_VISIBLE and line_y < V_VISIBLE.
REQ-015 locked  out  1  high in state LOCKED.
REQ-016 frame_start  out  1  one-clk pulse when position advances to (0,0) while LOCKED.
REQ-017 h_error, v_error  out  1 each  one-clk pulses on horizontal/vertical timing faults.

Function
REQ-018 The block SHALL register hsync_n and vsync_n once; a falling edge is previous sample 1, current sample 0.
REQ-019 sub_pixel counter SHALL increment each clk; pixel_tick SHALL be high when it equals all-ones.
REQ-020 On pixel_tick, pixel_x SHALL increment, wrapping PIXELS-1 -> 0; on that wrap, line_y SHALL increment, wrapping LINES-1 -> 0.
REQ-021 On an hsync falling edge, sub_pixel counter SHALL load 1, pixel_x SHALL load H_SYNC_START; this overrides REQ-020 in the same clk.
REQ-022 On a vsync falling edge, line_y SHALL load V_SYNC_START; this overrides REQ-020 line update in the same clk.
REQ-023 States: SEARCH, H_LOCK, LOCKED; reset state SEARCH.
REQ-024 SEARCH -> H_LOCK on first hsync falling edge.
REQ-025 H_LOCK -> LOCKED on a vsync falling edge whose previous hsync edge spacing was exactly PIXELS pixels.
REQ-026 In H_LOCK and LOCKED, an hsync falling edge occurring when pixel_x (before load) is not H_SYNC_START SHALL pulse h_error and move to SEARCH.
REQ-027 In LOCKED, a vsync falling edge when line_y (before load) is not V_SYNC_START SHALL pulse v_error and move to H_LOCK.
REQ-028 Watchdog: in H_LOCK or LOCKED, PIXELS+H_SYNC_START pixel_ticks without an hsync edge SHALL pulse h_error and move to SEARCH.
REQ-029 Simultaneous hsync and vsync faults SHALL pulse both flags; next state SEARCH.
REQ-030 frame_start, video_active SHALL be forced 0 outside LOCKED.
REQ-031 All outputs SHALL be registered; position, pixel_tick and flags are valid one clk after the sampled edge.

Reset
REQ-032 When reset = 0 or enable = 0 at posedge clk, all counters, pixel_x, line_y, state (SEARCH), sync history (1) and all outputs SHALL clear to 0 next clk.
REQ-033 Reset mid-frame SHALL discard lock; relock requires REQ-024/025 anew.
REQ-034 Deassertion SHALL require no settling cycles; a sync edge in the first enabled clk is decoded, since history resets to 1.

Verification
REQ-035 Drive standard 800x525 timing from a matching generator, two frames -> locked rises at first vsync edge of frame 1; frame_start pulses once per frame; pixel_x/line_y track generator exactly.
REQ-036 When locked, shift one hsync edge by 1 pixel (edge at 657) -> h_error one pulse, locked falls next clk, state SEARCH, relock after next valid vsync.
REQ-037 When locked, hold hsync_n high for 1500 pixels -> h_error pulse at tick PIXELS+H_SYNC_START after last edge, locked 0.
REQ-038 Vsync edge at line 489 while locked -> v_error pulse, state H_LOCK, line_y = 490.
REQ-039 Pull reset low for 1 clk at pixel_x = 300, line_y = 100 -> all outputs 0 next clk; enable low gives identical result.
REQ-040 Check video_active: high only for pixel_x 0..639, line_y 0..479 while locked; pixel_tick every 4th clk.
